uart_rx_param: RTL and testbench

Parametrised UART receiver for the PicoBlaze SoC, replacing the fixed-format receive path behind `rx`. It supports programmable frame format (5–8 data bits, optional odd/even parity) and a runtime baud divisor with configurable oversampling. Received words go into a first-word-fall-through receive FIFO read by the processor port logic, with sticky framing, parity and overrun flags.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_fifo.sv | 61 ++++++
 rtl/uart_rx_param.sv | 215 +++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame-length encoding, parity modes.
// Pure declarations; no timing or flow control.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

  localparam logic [1:0] LEN_5 = 2'b00;
  localparam logic [1:0] LEN_6 = 2'b01;
  localparam logic [1:0] LEN_7 = 2'b10;
  localparam logic [1:0] LEN_8 = 2'b11;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic logic [3:0] data_bits(input logic [1:0] len);
    return 4'd5 + {2'b00, len};
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO; head visible the clock after the write, next entry the clock after a pop.
// Writes while full are refused unless a pop happens in the same cycle; pops while empty are ignored.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dat,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_wr, do_rd;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == (PTR_W+1)'(DEPTH));
  assign do_rd  = rd_en && !empty;
  assign do_wr  = wr_en && (!full || do_rd);
  assign rd_dat = empty ? '0 : mem_q[rd_ptr_q];

  // Power-of-two depth lets the pointers wrap on their own.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat;
  end

endmodule

// File: rtl/uart_rx_param.sv
// Programmable-format UART receiver; word visible one clock after the stop sample. Optional FIFO under UART_RX_FIFO_EN,
// else a single holding register. No backpressure on the line: a word arriving while storage is full is dropped as overrun.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic [1:0]       data_len,
  input  logic             parity_en,
  input  logic             odd_n_even,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             rd_en,
  input  logic             err_clr,
  output logic [7:0]       rd_data,
  output logic             rx_valid,
  output logic             fifo_full,
  output logic             rx_busy,
  output logic             framing_err,
  output logic             parity_err,
  output logic             overrun_err
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST      = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);

  logic rx_meta_q, rx_s_q, rx_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end
  assign rx_s = rx_s_q;

  uart_state_e      state_q;
  logic [DIV_W-1:0] tick_cnt_q, div_q;
  logic [OS_W-1:0]  os_cnt_q;
  logic [3:0]       bit_cnt_q, nbits_q;
  logic [7:0]       data_q;
  logic             par_acc_q, par_bad_q, par_en_q, odd_q;
  logic             tick, half_smp, full_smp;

  assign tick     = (state_q != ST_IDLE) && (tick_cnt_q == div_q);
  assign half_smp = tick && (os_cnt_q == OS_HALF_LAST);
  assign full_smp = tick && (os_cnt_q == OS_LAST);
  assign rx_busy  = (state_q != ST_IDLE);

  // Frame format and divisor are captured at the start edge so mid-frame register writes cannot corrupt it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      div_q      <= '0;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      nbits_q    <= 4'd8;
      data_q     <= '0;
      par_acc_q  <= 1'b0;
      par_bad_q  <= 1'b0;
      par_en_q   <= 1'b0;
      odd_q      <= 1'b0;
    end else begin
      if (state_q != ST_IDLE) tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
      if (tick) os_cnt_q <= os_cnt_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (!rx_s) begin
            nbits_q    <= data_bits(data_len);
            par_en_q   <= parity_en;
            odd_q      <= odd_n_even;
            div_q      <= baud_div;
            tick_cnt_q <= '0;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            data_q     <= '0;
            par_acc_q  <= 1'b0;
            par_bad_q  <= 1'b0;
            state_q    <= ST_START;
          end
        end
        ST_START: begin
          if (half_smp) begin
            os_cnt_q <= '0;
            state_q  <= rx_s ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (full_smp) begin
            os_cnt_q               <= '0;
            data_q[bit_cnt_q[2:0]] <= rx_s;
            par_acc_q              <= par_acc_q ^ rx_s;
            bit_cnt_q              <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == nbits_q - 4'd1) state_q <= par_en_q ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          if (full_smp) begin
            os_cnt_q  <= '0;
            par_bad_q <= (rx_s != (par_acc_q ^ odd_q));
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (full_smp) begin
            os_cnt_q <= '0;
            state_q  <= rx_s ? ST_IDLE : ST_WAIT_HIGH;
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_s) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic       push_vld, push_acc, pop;
  logic       word_vld, word_full;
  logic [7:0] head_dat;

  assign push_vld = (state_q == ST_STOP) && full_smp && rx_s;
  assign pop      = rd_en && word_vld;
  assign push_acc = push_vld && (!word_full || pop);

`ifdef UART_RX_FIFO_EN
  logic fifo_empty;

  uart_rx_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (push_acc),
    .wr_dat (data_q),
    .rd_en  (pop),
    .rd_dat (head_dat),
    .empty  (fifo_empty),
    .full   (word_full)
  );
  assign word_vld = !fifo_empty;
`else
  logic       hold_vld_q, hold_vld_d;
  logic [7:0] hold_dat_q, hold_dat_d;
  logic       unused_depth;

  assign unused_depth = ^FIFO_DEPTH;

  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_dat_d = hold_dat_q;
    if (push_acc) begin
      hold_vld_d = 1'b1;
      hold_dat_d = data_q;
    end else if (pop) begin
      hold_vld_d = 1'b0;
      hold_dat_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_vld_q <= 1'b0;
      hold_dat_q <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
    end
  end

  assign word_vld  = hold_vld_q;
  assign word_full = hold_vld_q;
  assign head_dat  = hold_vld_q ? hold_dat_q : 8'h00;
`endif

  assign rd_data   = head_dat;
  assign rx_valid  = word_vld;
  assign fifo_full = word_full;

  logic frm_q, frm_d, par_q, par_d, ovr_q, ovr_d;

  // A set in the same cycle as err_clr wins.
  always_comb begin
    frm_d = ((state_q == ST_STOP) && full_smp && !rx_s) || (frm_q && !err_clr);
    par_d = (push_vld && par_bad_q) || (par_q && !err_clr);
    ovr_d = (push_vld && !push_acc) || (ovr_q && !err_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frm_q <= 1'b0;
      par_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      frm_q <= frm_d;
      par_q <= par_d;
      ovr_q <= ovr_d;
    end
  end

  assign framing_err = frm_q;
  assign parity_err  = par_q;
  assign overrun_err = ovr_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: serial frames in, expected words queued, popped words compared.
module tb_uart_rx_param;

`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 1;
`endif
  localparam int BIT = 80;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic [1:0]  data_len = 2'b11;
  logic        parity_en = 1'b0;
  logic        odd_n_even = 1'b0;
  logic [15:0] baud_div = 16'd4;
  logic        rd_en = 1'b0;
  logic        err_clr = 1'b0;
  logic [7:0]  rd_data;
  logic        rx_valid, fifo_full, rx_busy, framing_err, parity_err, overrun_err;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_param #(.OVERSAMPLE(16), .DIV_W(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .rx(rx), .data_len(data_len), .parity_en(parity_en),
    .odd_n_even(odd_n_even), .baud_div(baud_div), .rd_en(rd_en), .err_clr(err_clr),
    .rd_data(rd_data), .rx_valid(rx_valid), .fifo_full(fifo_full), .rx_busy(rx_busy),
    .framing_err(framing_err), .parity_err(parity_err), .overrun_err(overrun_err)
  );

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drives start, nbits data LSB first, optional parity (flip inverts it), then one stop bit of value stop.
  task automatic send_frame(input logic [7:0] d, input int nbits, input bit pen, input bit odd,
                            input bit flip, input bit stop);
    logic [7:0] mask;
    mask = 8'hFF >> (8 - nbits);
    rx = 1'b0;
    clks(BIT);
    for (int i = 0; i < nbits; i++) begin
      rx = d[i];
      clks(BIT);
    end
    if (pen) begin
      rx = (^(d & mask)) ^ odd ^ flip;
      clks(BIT);
    end
    rx = stop;
    clks(BIT);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    check({tag, "_vld"}, {31'b0, rx_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_sb: observed %0h expected none", tag, rd_data);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_dat"}, {24'b0, rd_data}, {24'b0, e});
    end
    rd_en = 1'b1;
    clks(1);
    rd_en = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    clks(1);
    err_clr = 1'b0;
    check("err_clr", {29'b0, framing_err, parity_err, overrun_err}, 32'd0);
  endtask

  initial begin
    clks(4);
    check("reset_outs", {18'b0, rd_data, rx_valid, fifo_full, rx_busy, framing_err, parity_err, overrun_err}, 32'd0);
    reset = 1'b1;
    clks(4);

    // 8N1 0xA5
    send_frame(8'hA5, 8, 0, 0, 0, 1);
    exp_q.push_back(8'hA5);
    check("8n1_flags", {29'b0, framing_err, parity_err, overrun_err}, 32'd0);
    pop_check("8n1");
    check("8n1_empty", {23'b0, rx_valid, rd_data}, 32'd0);

    // 7 data bits, odd parity, good then bad parity
    data_len = 2'b10; parity_en = 1'b1; odd_n_even = 1'b1;
    send_frame(8'h5A, 7, 1, 1, 0, 1);
    exp_q.push_back(8'h5A);
    check("7o1_perr", {31'b0, parity_err}, 32'd0);
    pop_check("7o1");
    send_frame(8'h5A, 7, 1, 1, 1, 1);
    exp_q.push_back(8'h5A);
    check("7o1_bad_perr", {31'b0, parity_err}, 32'd1);
    pop_check("7o1_bad");
    clear_errs();

    // 5 data bits, even parity, upper bits must read as zero
    data_len = 2'b00; odd_n_even = 1'b0;
    send_frame(8'hF6, 5, 1, 0, 0, 1);
    exp_q.push_back(8'h16);
    check("5e1_perr", {31'b0, parity_err}, 32'd0);
    pop_check("5e1");

    // Framing error, then line held low in WAIT_HIGH
    data_len = 2'b11; parity_en = 1'b0;
    send_frame(8'h81, 8, 0, 0, 0, 0);
    clks(3 * BIT);
    check("frm_state", {29'b0, rx_busy, framing_err, rx_valid}, 32'b110);
    rx = 1'b1;
    clks(BIT);
    check("frm_idle", {31'b0, rx_busy}, 32'd0);
    send_frame(8'h3C, 8, 0, 0, 0, 1);
    exp_q.push_back(8'h3C);
    pop_check("frm_next");
    clear_errs();

    // Glitch rejected as false start
    rx = 1'b0;
    clks(20);
    rx = 1'b1;
    check("glitch_busy", {31'b0, rx_busy}, 32'd1);
    clks(100);
    check("glitch_after", {27'b0, rx_busy, rx_valid, framing_err, parity_err, overrun_err}, 32'd0);

    // Format change mid-frame must not affect the frame in flight
    fork
      send_frame(8'hC3, 8, 0, 0, 0, 1);
      begin
        clks(300);
        data_len = 2'b00; parity_en = 1'b1; baud_div = 16'd9;
      end
    join
    exp_q.push_back(8'hC3);
    check("midcfg_flags", {29'b0, framing_err, parity_err, overrun_err}, 32'd0);
    pop_check("midcfg");
    data_len = 2'b11; parity_en = 1'b0; baud_div = 16'd4;

    // Overrun: DEPTH+1 frames without reads
    for (int i = 0; i < DEPTH + 1; i++) begin
      send_frame(8'h10 + 8'(i), 8, 0, 0, 0, 1);
      if (i < DEPTH) exp_q.push_back(8'h10 + 8'(i));
      if (i == DEPTH - 1) check("ovr_full", {30'b0, fifo_full, overrun_err}, 32'b10);
    end
    check("ovr_set", {30'b0, fifo_full, overrun_err}, 32'b11);
    for (int i = 0; i < DEPTH; i++) pop_check("ovr_pop");
    check("ovr_empty", {31'b0, rx_valid}, 32'd0);
    clear_errs();

    // Reset in the middle of a frame with a word stored and a flag set
    send_frame(8'h11, 8, 0, 0, 0, 1);
    send_frame(8'h22, 8, 0, 0, 0, 1);
    check("rst_pre", {30'b0, rx_valid, overrun_err}, DEPTH == 1 ? 32'b11 : 32'b10);
    rx = 1'b0;
    clks(250);
    check("rst_busy", {31'b0, rx_busy}, 32'd1);
    reset = 1'b0;
    #1;
    check("rst_mid", {18'b0, rd_data, rx_valid, fifo_full, rx_busy, framing_err, parity_err, overrun_err}, 32'd0);
    rx = 1'b1;
    clks(3);
    reset = 1'b1;
    clks(20);
    exp_q.delete();
    send_frame(8'h96, 8, 0, 0, 0, 1);
    exp_q.push_back(8'h96);
    pop_check("rst_next");
    check("rst_left", {31'b0, rx_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
